// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the eight-digit seven-segment scanner.
// lzb_mask() backs the optional leading-zero blanking (SEG_LZB_EN).
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned DATA_W     = NUM_DIGITS * NIBBLE_W;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } seg_state_e;

    // Digit k survives if it is digit 0 or any nibble at or above k is nonzero.
    function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [DATA_W-1:0] data);
        logic                  seen;
        logic [NUM_DIGITS-1:0] mask;
        seen = 1'b0;
        mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen    = seen | (data[k*NIBBLE_W +: NIBBLE_W] != '0);
            mask[k] = seen | (k == 0);
        end
        return mask;
    endfunction

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Per-digit slot timer: counts 0..SLOT_CYC-1, BLANK for the first BLANK_CYC cycles,
// then SHOW; o_slot_end flags the last SHOW cycle.
module seven_seg_slot_timer
    import seven_seg_pkg::*;
#(
    parameter int unsigned SLOT_CYC  = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    output seg_state_e o_state,
    output logic       o_slot_end
);

    localparam int unsigned CNT_W = $clog2(SLOT_CYC);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    seg_state_e       r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_state <= BLANK;
        end else begin
            unique case (r_state)
                BLANK: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == BLANK_END) begin
                        r_state <= SHOW;
                    end
                end
                SHOW: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt   <= '0;
                        r_state <= BLANK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= BLANK;
                end
            endcase
        end
    end

    assign o_state    = r_state;
    assign o_slot_end = (r_state == SHOW) && (r_cnt == LAST_CNT);

endmodule

// File: rtl/seven_seg_scan.sv
// Eight-digit multiplexed display scanner with double-buffered, tear-free data update.
// Define SEG_LZB_EN to blank leading zero digits.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned SLOT_CYC  = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic [NUM_DIGITS-1:0] en_in,
    output logic [NIBBLE_W-1:0]   digit,
    output logic [NUM_DIGITS-1:0] an_sel,
    output logic                  dp_out,
    output logic                  frame_done
);

    seg_state_e            w_state;
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_show;
    logic                  w_active;
    logic [NUM_DIGITS-1:0] w_act_mask;
    logic [NUM_DIGITS-1:0] w_onehot;

    logic [IDX_W-1:0]      r_idx;
    logic [DATA_W-1:0]     r_act_data;
    logic [NUM_DIGITS-1:0] r_act_dp;
    logic [NUM_DIGITS-1:0] r_act_en;
    logic [DATA_W-1:0]     r_pend_data;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic [NUM_DIGITS-1:0] r_pend_en;
    logic                  r_pend;
    logic [NIBBLE_W-1:0]   r_digit;
    logic [NUM_DIGITS-1:0] r_an_sel;
    logic                  r_dp_out;
    logic                  r_frame_done;

    seven_seg_slot_timer #(
        .SLOT_CYC  (SLOT_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_state    (w_state),
        .o_slot_end (w_slot_end)
    );

    assign w_frame_end = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_show      = (w_state == SHOW);
    assign w_onehot    = NUM_DIGITS'(1) << r_idx;

`ifdef SEG_LZB_EN
    logic [NUM_DIGITS-1:0] r_lzb_mask;

    // Mask tracks the active data, so it only moves on a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lzb_mask <= NUM_DIGITS'(1);
        end else if (w_frame_end && load) begin
            r_lzb_mask <= lzb_mask(data_in);
        end else if (w_frame_end && r_pend) begin
            r_lzb_mask <= lzb_mask(r_pend_data);
        end
    end

    assign w_act_mask = r_act_en & r_lzb_mask;
`else
    assign w_act_mask = r_act_en;
`endif

    assign w_active = w_act_mask[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_en     <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_en    <= '0;
            r_pend       <= 1'b0;
            r_digit      <= '0;
            r_an_sel     <= '0;
            r_dp_out     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_idx <= r_idx + 1'b1;
            end

            // Active registers only change on the frame boundary.
            if (w_frame_end && load) begin
                r_act_data <= data_in;
                r_act_dp   <= dp_in;
                r_act_en   <= en_in;
                r_pend     <= 1'b0;
            end else if (w_frame_end && r_pend) begin
                r_act_data <= r_pend_data;
                r_act_dp   <= r_pend_dp;
                r_act_en   <= r_pend_en;
                r_pend     <= 1'b0;
            end else if (load) begin
                r_pend_data <= data_in;
                r_pend_dp   <= dp_in;
                r_pend_en   <= en_in;
                r_pend      <= 1'b1;
            end

            r_digit      <= w_show ? r_act_data[{r_idx, 2'b00} +: NIBBLE_W] : '0;
            r_an_sel     <= (w_show && w_active) ? w_onehot : '0;
            r_dp_out     <= w_show && w_active && r_act_dp[r_idx];
            r_frame_done <= w_frame_end;
        end
    end

    assign digit      = r_digit;
    assign an_sel     = r_an_sel;
    assign dp_out     = r_dp_out;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with a behavioural scoreboard of the display scan.
module tb_seven_seg_scan;
    import seven_seg_pkg::*;

    localparam int unsigned SLOT_CYC  = 8;
    localparam int unsigned BLANK_CYC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  en_in;
    logic [3:0]  digit;
    logic [7:0]  an_sel;
    logic        dp_out;
    logic        frame_done;

    seven_seg_scan #(
        .SLOT_CYC  (SLOT_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .en_in      (en_in),
        .digit      (digit),
        .an_sel     (an_sel),
        .dp_out     (dp_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [3:0] dig;
        logic       dp;
        logic       fd;
        logic       show;
    } exp_t;

    exp_t exp_q[$];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          fd_seen;
    logic [7:0]  an_acc;

    int          m_cnt;
    int          m_idx;
    logic [31:0] m_act_data, m_pend_data;
    logic [7:0]  m_act_dp, m_pend_dp, m_act_en, m_pend_en;
    logic        m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model_lzb(input logic [31:0] d);
        logic [7:0] m;
        logic       nz;
        nz = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (d[k*4 +: 4] != 4'h0) nz = 1'b1;
            m[k] = nz || (k == 0);
        end
        return m;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_pend = 1'b0;
        m_act_data = '0; m_act_dp = '0; m_act_en = '0;
        m_pend_data = '0; m_pend_dp = '0; m_pend_en = '0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, predict registered outputs, then compare after the edge.
    task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] dp,
                        input logic [7:0] en);
        exp_t       e;
        logic       show, act, boundary;
        logic [7:0] mask;
        load = ld; data_in = d; dp_in = dp; en_in = en;
        show = (m_cnt >= int'(BLANK_CYC));
        mask = m_act_en;
`ifdef SEG_LZB_EN
        mask = mask & model_lzb(m_act_data);
`endif
        act      = mask[m_idx];
        boundary = (m_cnt == int'(SLOT_CYC) - 1) && (m_idx == 7);
        e.an   = (show && act) ? (8'h01 << m_idx) : 8'h00;
        e.dp   = show && act && m_act_dp[m_idx];
        e.dig  = m_act_data[m_idx*4 +: 4];
        e.fd   = boundary;
        e.show = show;
        exp_q.push_back(e);
        if (boundary && ld) begin
            m_act_data = d; m_act_dp = dp; m_act_en = en; m_pend = 1'b0;
        end else if (boundary && m_pend) begin
            m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_en = m_pend_en;
            m_pend = 1'b0;
        end else if (ld) begin
            m_pend_data = d; m_pend_dp = dp; m_pend_en = en; m_pend = 1'b1;
        end
        m_cnt++;
        if (m_cnt == int'(SLOT_CYC)) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 8;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        if (frame_done) fd_seen++;
        an_acc = an_acc | an_sel;
        e = exp_q.pop_front();
        chk("an_sel", 32'(an_sel), 32'(e.an));
        chk("dp_out", 32'(dp_out), 32'(e.dp));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        if (e.show) chk("digit", 32'(digit), 32'(e.dig));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 8'h0, 8'h0);
    endtask

    task automatic run_until(input int idx, input int cnt);
        int n;
        n = 0;
        while (!(m_idx == idx && m_cnt == cnt) && n < 600) begin
            step(1'b0, 32'h0, 8'h0, 8'h0);
            n++;
        end
        if (!(m_idx == idx && m_cnt == cnt)) begin
            n_chk++;
            n_fail++;
            $display("FAIL run_until observed=%0d/%0d expected=%0d/%0d", m_idx, m_cnt, idx, cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; en_in = '0;
        fd_seen = 0; an_acc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an_sel", 32'(an_sel), 32'h0);
        chk("rst_digit", 32'(digit), 32'h0);
        chk("rst_dp_out", 32'(dp_out), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        #2 rst_n = 1'b1;

        // Basic scan: data becomes visible one frame after the load.
        step(1'b1, 32'h7654_3210, 8'h01, 8'hFF);
        idle(127);

        // Mid-frame load must not tear the current frame.
        run_until(3, 0);
        step(1'b1, 32'hFFFF_FFFF, 8'h00, 8'hFF);
        fd_seen = 0;
        idle(128);
        chk("fd_per_128", 32'(fd_seen), 32'd2);

        // Disabled digits keep their slots.
        step(1'b1, 32'h1357_2468, 8'h0F, 8'h0F);
        run_until(0, 0);
        an_acc = '0; fd_seen = 0;
        idle(64);
        chk("en_0f_anodes", 32'(an_acc), 32'h0F);
        chk("en_0f_period", 32'(fd_seen), 32'd1);

        // Load exactly on the frame boundary goes straight to active.
        run_until(7, 7);
        step(1'b1, 32'h89AB_CDEF, 8'hAA, 8'hFF);
        chk("boundary_pend", 32'(dut.r_pend), 32'h0);
        idle(64);

        // Asynchronous reset in the SHOW phase of digit 3.
        run_until(3, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_an_sel", 32'(an_sel), 32'h0);
        chk("mid_rst_digit", 32'(digit), 32'h0);
        chk("mid_rst_dp_out", 32'(dp_out), 32'h0);
        chk("mid_rst_frame_done", 32'(frame_done), 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        step(1'b1, 32'h0000_00A5, 8'h01, 8'hFF);
        chk("post_rst_blank", 32'(dut.u_timer.r_state), 32'(BLANK));
        idle(1);
        chk("post_rst_show", 32'(dut.u_timer.r_state), 32'(SHOW));
        fd_seen = 0;
        idle(140);
        chk("post_rst_frames", 32'(fd_seen), 32'd2);

`ifdef SEG_LZB_EN
        step(1'b1, 32'h0000_0120, 8'h00, 8'hFF);
        run_until(0, 0);
        an_acc = '0;
        idle(64);
        chk("lzb_120_anodes", 32'(an_acc), 32'h07);
        step(1'b1, 32'h0000_0000, 8'h00, 8'hFF);
        run_until(0, 0);
        an_acc = '0;
        idle(64);
        chk("lzb_zero_anodes", 32'(an_acc), 32'h01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
